mips_lsu_mem_master: RTL and testbench

//  CPU-side initiator for the data-memory port (data_address/data_write/data_read/

---
 rtl/mips_lsu_mem_master_if.sv | 30 +++
 rtl/mips_lsu_mem_master.sv | 194 +++++++++++++++++++
 tb/tb_mips_lsu_mem_master.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_lsu_mem_master_if.sv
// Request/response and data-memory signals between the MIPS MEM stage and its
// load/store master. The master modport is the LSU; slave is core plus RAM.
interface mips_lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, data_readdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           data_address, data_read, data_write, data_writedata
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, data_readdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
           data_address, data_read, data_write, data_writedata
  );
endinterface

// File: rtl/mips_lsu_mem_master.sv
// MIPS load/store unit driving a word-only data RAM. Sub-word stores are done as
// read-modify-write; all memory-side and response outputs are registered.
module mips_lsu_mem_master #(
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  mips_lsu_mem_master_if.master  lsu_if
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic        data_read_q, data_read_d;
  logic        data_write_q, data_write_d;
  logic [31:0] data_address_q, data_address_d;
  logic [31:0] data_writedata_q, data_writedata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        ready_s;
  logic        accept_s;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lane);
    case (op)
      OP_LH, OP_LHU, OP_SH: return lane[0];
      OP_LW, OP_SW:         return (lane != 2'b00);
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_lane(input logic [2:0] op, input logic [1:0] lane);
    case (op)
      OP_LH, OP_LHU, OP_SH: return {lane[1], 1'b0};
      OP_LW, OP_SW:         return 2'b00;
      default:              return lane;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] lane,
                                          input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'd0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'd0, h};
      OP_LW:   return word;
      default: return 32'd0;
    endcase
  endfunction

  // Only the addressed byte/halfword lane is replaced in the word read back.
  function automatic logic [31:0] merge(input logic [2:0] op, input logic [1:0] lane,
                                        input logic [31:0] word, input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    case (op)
      OP_SB: r[{lane, 3'b000} +: 8] = wd[7:0];
      OP_SH: begin
        if (lane[1]) r[31:16] = wd;
        else         r[15:0]  = wd;
      end
      default: r = word;
    endcase
    return r;
  endfunction

  assign ready_s  = (state_q == S_IDLE) && !reset;
  assign accept_s = lsu_if.req_valid && ready_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!accept_s) begin
          state_d = S_IDLE;
        end else if (ERR_ON_MISALIGN && misaligned(lsu_if.req_op, lsu_if.req_addr[1:0])) begin
          state_d = S_RESP;
        end else if (lsu_if.req_op == OP_SW) begin
          state_d = S_WR;
        end else begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (is_store(op_q)) state_d = S_WR;
        else                state_d = S_RESP;
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values, registered below so every strobe is a flop
  always_comb begin
    data_read_d      = (state_d == S_RD);
    data_write_d     = (state_d == S_WR);
    resp_valid_d     = (state_d == S_RESP);
    resp_err_d       = (state_q == S_IDLE) && (state_d == S_RESP);
    op_d             = op_q;
    lane_d           = lane_q;
    wdata_d          = wdata_q;
    data_address_d   = data_address_q;
    data_writedata_d = data_writedata_q;
    resp_rdata_d     = resp_rdata_q;
    if (accept_s) begin
      op_d             = lsu_if.req_op;
      lane_d           = align_lane(lsu_if.req_op, lsu_if.req_addr[1:0]);
      wdata_d          = lsu_if.req_wdata[15:0];
      data_address_d   = {lsu_if.req_addr[31:2], 2'b00};
      data_writedata_d = lsu_if.req_wdata;
      resp_rdata_d     = 32'd0;
    end else if (state_q == S_RD) begin
      if (is_store(op_q)) begin
        data_writedata_d = merge(op_q, lane_q, lsu_if.data_readdata, wdata_q);
      end else begin
        resp_rdata_d = extract(op_q, lane_q, lsu_if.data_readdata);
      end
    end else begin
      resp_rdata_d = resp_rdata_q;
    end
  end

  // Output and captured-request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q             <= 3'd0;
      lane_q           <= 2'd0;
      wdata_q          <= 16'd0;
      data_read_q      <= 1'b0;
      data_write_q     <= 1'b0;
      data_address_q   <= 32'd0;
      data_writedata_q <= 32'd0;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      resp_rdata_q     <= 32'd0;
    end else begin
      op_q             <= op_d;
      lane_q           <= lane_d;
      wdata_q          <= wdata_d;
      data_read_q      <= data_read_d;
      data_write_q     <= data_write_d;
      data_address_q   <= data_address_d;
      data_writedata_q <= data_writedata_d;
      resp_valid_q     <= resp_valid_d;
      resp_err_q       <= resp_err_d;
      resp_rdata_q     <= resp_rdata_d;
    end
  end

  assign lsu_if.req_ready      = ready_s;
  assign lsu_if.busy           = !ready_s;
  assign lsu_if.data_read      = data_read_q;
  assign lsu_if.data_write     = data_write_q;
  assign lsu_if.data_address   = data_address_q;
  assign lsu_if.data_writedata = data_writedata_q;
  assign lsu_if.resp_valid     = resp_valid_q;
  assign lsu_if.resp_err       = resp_err_q;
  assign lsu_if.resp_rdata     = resp_rdata_q;

endmodule

// File: tb/tb_mips_lsu_mem_master.sv
// Directed bench for mips_lsu_mem_master with a word RAM model and a response scoreboard.
module tb_mips_lsu_mem_master;
  logic clk;
  logic reset;
  logic mem_init;
  int   checks;
  int   errors;
  int   wr_cnt;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wword;
  } exp_t;

  exp_t sb_q[$];

  mips_lsu_mem_master_if b1 ();
  mips_lsu_mem_master_if b0 ();

  mips_lsu_mem_master #(.ERR_ON_MISALIGN(1'b1)) dut (.clk(clk), .reset(reset), .lsu_if(b1));
  mips_lsu_mem_master #(.ERR_ON_MISALIGN(1'b0)) dut0 (.clk(clk), .reset(reset), .lsu_if(b0));

  logic [31:0] mem1 [0:63];
  logic [31:0] mem0 [0:63];

  assign b1.data_readdata = mem1[b1.data_address[7:2]];
  assign b0.data_readdata = mem0[b0.data_address[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem1[i] <= 32'd0;
        mem0[i] <= 32'd0;
      end
      mem1[8]  <= 32'h8000FF7F;
      mem1[63] <= 32'h11223344;
      mem0[8]  <= 32'h8000FF7F;
    end else begin
      if (b1.data_write) mem1[b1.data_address[7:2]] <= b1.data_writedata;
      if (b0.data_write) mem0[b0.data_address[7:2]] <= b0.data_writedata;
    end
  end

  always @(posedge clk) begin
    if (b1.data_write) wr_cnt <= wr_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                              input int nrd, input int nwr,
                              input logic [31:0] waddr, input logic [31:0] wword);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat; e.nrd = nrd; e.nwr = nwr;
    e.waddr = waddr; e.wword = wword;
    return e;
  endfunction

  task automatic txn(input string tag, input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input exp_t e);
    int n, nrd, nwr, w, both;
    logic [31:0] wa, wd;
    logic got;
    exp_t x;
    wa = 32'd0; wd = 32'd0; nrd = 0; nwr = 0; both = 0; got = 1'b0;
    @(negedge clk);
    b1.req_valid = 1'b1; b1.req_op = op; b1.req_addr = addr; b1.req_wdata = wdata;
    w = 0;
    while (!b1.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " ready"}, {31'd0, b1.req_ready}, 32'd1);
    sb_q.push_back(e);
    @(negedge clk);
    b1.req_valid = 1'b0; b1.req_op = 3'd7; b1.req_addr = 32'hFFFF_FFF1; b1.req_wdata = 32'h5A5A5A5A;
    n = 1;
    while (n <= 10) begin
      if (b1.data_read) nrd++;
      if (b1.data_write) begin
        nwr++; wa = b1.data_address; wd = b1.data_writedata;
      end
      if (b1.data_read && b1.data_write) both++;
      if (b1.resp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    chk({tag, " resp_seen"}, {31'd0, got}, 32'd1);
    x = sb_q.pop_front();
    chk({tag, " latency"}, n, x.lat);
    chk({tag, " rdata"}, b1.resp_rdata, x.rdata);
    chk({tag, " err"}, {31'd0, b1.resp_err}, {31'd0, x.err});
    chk({tag, " reads"}, nrd, x.nrd);
    chk({tag, " writes"}, nwr, x.nwr);
    chk({tag, " rd_wr_overlap"}, both, 0);
    if (x.nwr > 0) begin
      chk({tag, " waddr"}, wa, x.waddr);
      chk({tag, " wword"}, wd, x.wword);
    end
    @(negedge clk);
    chk({tag, " resp_pulse"}, {31'd0, b1.resp_valid}, 32'd0);
  endtask

  initial begin
    int acc, rsp, bad, wr_before;
    checks = 0; errors = 0; wr_cnt = 0;
    reset = 1'b1; mem_init = 1'b1;
    b1.req_valid = 1'b0; b1.req_op = 3'd0; b1.req_addr = 32'd0; b1.req_wdata = 32'd0;
    b0.req_valid = 1'b0; b0.req_op = 3'd0; b0.req_addr = 32'd0; b0.req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst req_ready", {31'd0, b1.req_ready}, 32'd0);
    chk("rst busy", {31'd0, b1.busy}, 32'd1);
    chk("rst strobes", {30'd0, b1.data_read, b1.data_write}, 32'd0);
    chk("rst resp", {30'd0, b1.resp_valid, b1.resp_err}, 32'd0);
    chk("rst data_address", b1.data_address, 32'd0);
    chk("rst data_writedata", b1.data_writedata, 32'd0);
    chk("rst resp_rdata", b1.resp_rdata, 32'd0);
    reset = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    chk("post-rst req_ready", {31'd0, b1.req_ready}, 32'd1);

    txn("LB 0x20",  3'd0, 32'h20, 32'd0, mk(32'h0000007F, 1'b0, 2, 1, 0, 32'd0, 32'd0));
    txn("LB 0x21",  3'd0, 32'h21, 32'd0, mk(32'hFFFFFFFF, 1'b0, 2, 1, 0, 32'd0, 32'd0));
    txn("LBU 0x21", 3'd1, 32'h21, 32'd0, mk(32'h000000FF, 1'b0, 2, 1, 0, 32'd0, 32'd0));
    txn("LH 0x22",  3'd2, 32'h22, 32'd0, mk(32'hFFFF8000, 1'b0, 2, 1, 0, 32'd0, 32'd0));
    txn("LHU 0x22", 3'd3, 32'h22, 32'd0, mk(32'h00008000, 1'b0, 2, 1, 0, 32'd0, 32'd0));
    txn("LH 0x20",  3'd2, 32'h20, 32'd0, mk(32'hFFFFFF7F, 1'b0, 2, 1, 0, 32'd0, 32'd0));
    txn("LW 0x20",  3'd4, 32'h20, 32'd0, mk(32'h8000FF7F, 1'b0, 2, 1, 0, 32'd0, 32'd0));
    txn("SB 0x21",  3'd5, 32'h21, 32'h000000AB, mk(32'd0, 1'b0, 3, 1, 1, 32'h20, 32'h8000AB7F));
    txn("SH 0x22",  3'd6, 32'h22, 32'h00001234, mk(32'd0, 1'b0, 3, 1, 1, 32'h20, 32'h1234AB7F));
    txn("LW after RMW", 3'd4, 32'h20, 32'd0, mk(32'h1234AB7F, 1'b0, 2, 1, 0, 32'd0, 32'd0));
    txn("SW 0x24",  3'd7, 32'h24, 32'hDEADBEEF, mk(32'd0, 1'b0, 2, 0, 1, 32'h24, 32'hDEADBEEF));
    txn("LW 0x24",  3'd4, 32'h24, 32'd0, mk(32'hDEADBEEF, 1'b0, 2, 1, 0, 32'd0, 32'd0));
    txn("LH 0x23 mis", 3'd2, 32'h23, 32'd0, mk(32'd0, 1'b1, 1, 0, 0, 32'd0, 32'd0));
    txn("SW 0x22 mis", 3'd7, 32'h22, 32'hFFFFFFFF, mk(32'd0, 1'b1, 1, 0, 0, 32'd0, 32'd0));
    txn("LW 0x21 mis", 3'd4, 32'h21, 32'd0, mk(32'd0, 1'b1, 1, 0, 0, 32'd0, 32'd0));
    txn("LW 0x20 intact", 3'd4, 32'h20, 32'd0, mk(32'h1234AB7F, 1'b0, 2, 1, 0, 32'd0, 32'd0));
    txn("LB wrap",  3'd0, 32'hFFFFFFFF, 32'd0, mk(32'h00000011, 1'b0, 2, 1, 0, 32'd0, 32'd0));
    txn("LHU wrap", 3'd3, 32'hFFFFFFFE, 32'd0, mk(32'h00001122, 1'b0, 2, 1, 0, 32'd0, 32'd0));

    // Reset during the RD cycle of an SB must drop the pending write
    @(negedge clk);
    wr_before = wr_cnt;
    b1.req_valid = 1'b1; b1.req_op = 3'd5; b1.req_addr = 32'h21; b1.req_wdata = 32'h000000CD;
    @(negedge clk);
    b1.req_valid = 1'b0;
    chk("rst-rmw in RD", {31'd0, b1.data_read}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst-rmw ready low", {31'd0, b1.req_ready}, 32'd0);
    chk("rst-rmw strobes", {30'd0, b1.data_read, b1.data_write}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst-rmw ready high", {31'd0, b1.req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("rst-rmw no write", wr_cnt - wr_before, 0);
    txn("LW after reset", 3'd4, 32'h20, 32'd0, mk(32'h1234AB7F, 1'b0, 2, 1, 0, 32'd0, 32'd0));

    // Back-to-back with req_valid held: one accept every three cycles
    @(negedge clk);
    acc = 0; rsp = 0; bad = 0;
    b1.req_valid = 1'b1; b1.req_op = 3'd4; b1.req_addr = 32'h24;
    for (int i = 0; i < 9; i++) begin
      if (b1.req_valid && b1.req_ready) acc++;
      if (b1.resp_valid) begin
        rsp++;
        if (b1.resp_rdata !== 32'hDEADBEEF) bad++;
      end
      if (b1.busy !== !b1.req_ready) bad++;
      @(negedge clk);
    end
    b1.req_valid = 1'b0;
    chk("b2b accepts", acc, 3);
    chk("b2b responses", rsp, 3);
    chk("b2b data/busy", bad, 0);
    repeat (3) @(negedge clk);

    // Force-align instance: LH 0x23 reads the halfword at 0x22
    b0.req_valid = 1'b1; b0.req_op = 3'd2; b0.req_addr = 32'h23;
    @(negedge clk);
    b0.req_valid = 1'b0;
    chk("align LH RD", {31'd0, b0.data_read}, 32'd1);
    @(negedge clk);
    chk("align LH resp", {31'd0, b0.resp_valid}, 32'd1);
    chk("align LH rdata", b0.resp_rdata, 32'hFFFF8000);
    chk("align LH err", {31'd0, b0.resp_err}, 32'd0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
